// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, the TX/RX FSM state encoding and a
// helper giving the number of bit periods one character occupies on the line.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_GAP    = 3'd5,
      S_DONE   = 3'd6
   } uart_state_e;

   function automatic int unsigned uart_bits_per_char(
      input int unsigned start_en,
      input int unsigned byte_size,
      input int unsigned parity_mode,
      input int unsigned stop_bits
   );
      return start_en + byte_size + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: o_bit_tick_c is high in the last cycle of every
// CLKS_PER_BIT-cycle period; i_clear restarts the period.
module uart_baud_gen #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_bit_tick_c
);

   // One bit is kept for CLKS_PER_BIT=1 so the counter stays a real signal.
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CNT_W-1:0] r_cnt;

   assign o_bit_tick_c = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_cnt <= '0;
      end else if (o_bit_tick_c) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/uart_frame_tx.sv
// Multi-byte UART transmitter: serialises len bytes of full_data, byte 0
// first, each framed as start / data LSB-first / parity / stop / inter-byte gap.
module uart_frame_tx
   import uart_pkg::*;
#(
   parameter int unsigned FULL_DATA_SIZE = 40,
   parameter int unsigned BYTE_SIZE      = 8,
   parameter int unsigned CLKS_PER_BIT   = 4,
   parameter int unsigned START_EN       = 1,
   parameter int unsigned STOP_BITS      = 1,
   parameter int unsigned PARITY_MODE    = 0,
   parameter int unsigned GAP_BITS       = 0,
   localparam int unsigned MAX_BYTES     = FULL_DATA_SIZE / BYTE_SIZE,
   localparam int unsigned LEN_W         = $clog2(MAX_BYTES + 1)
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [FULL_DATA_SIZE-1:0] full_data,
   input  logic [LEN_W-1:0]          len,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic                      out_bit,
   output logic                      busy,
   output logic                      done
);

   localparam int unsigned BIT_W   = $clog2(BYTE_SIZE);
   localparam int unsigned PER_MAX = (STOP_BITS > GAP_BITS) ? STOP_BITS : GAP_BITS;
   localparam int unsigned PER_W   = (PER_MAX > 1) ? $clog2(PER_MAX) : 1;
   localparam logic        ODD_INV = 1'(PARITY_MODE == PARITY_ODD);

   uart_state_e               r_state;
   uart_state_e               w_nxt_state;
   logic                      r_out_bit;
   logic                      r_in_ready;
   logic                      r_busy;
   logic                      r_done;
   logic [BYTE_SIZE-1:0]      r_data;
   logic [FULL_DATA_SIZE-1:0] r_frame;
   logic                      r_par;
   logic [LEN_W-1:0]          r_len;
   logic [LEN_W-1:0]          r_byte_idx;
   logic [BIT_W-1:0]          r_bit_idx;
   logic [PER_W-1:0]          r_per_cnt;

   logic             w_tick;
   logic             w_baud_clr;
   logic             w_nxt_bit;
   logic             w_load;
   logic             w_last;
   logic             w_acc_par;
   logic             w_ld_par;
   logic [LEN_W-1:0] w_len_clamped;
   logic             w_from_data;
   logic             w_from_par;
   logic             w_from_stop;
   logic             w_from_gap;

   assign in_ready = r_in_ready;
   assign out_bit  = r_out_bit;
   assign busy     = r_busy;
   assign done     = r_done;

   assign w_baud_clr    = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_len_clamped = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
   assign w_last        = (r_byte_idx == (r_len - LEN_W'(1)));
   assign w_acc_par     = (^full_data[BYTE_SIZE-1:0]) ^ ODD_INV;
   assign w_ld_par      = (^r_frame[BYTE_SIZE-1:0]) ^ ODD_INV;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .i_clk        (CLK),
      .i_rst        (RST),
      .i_clear      (w_baud_clr),
      .o_bit_tick_c (w_tick)
   );

   // Where the line goes when the current bit period ends; disabled stages fall through.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_bit   = r_out_bit;
      w_load      = 1'b0;
      w_from_data = 1'b0;
      w_from_par  = 1'b0;
      w_from_stop = 1'b0;
      w_from_gap  = 1'b0;
      case (r_state)
         S_START: begin
            w_nxt_state = S_DATA;
            w_nxt_bit   = r_data[0];
         end
         S_DATA: begin
            if (r_bit_idx != BIT_W'(BYTE_SIZE - 1)) w_nxt_bit = r_data[1];
            else                                    w_from_data = 1'b1;
         end
         S_PARITY: w_from_par = 1'b1;
         S_STOP: begin
            if (r_per_cnt != PER_W'(STOP_BITS - 1)) w_nxt_bit = 1'b1;
            else                                    w_from_stop = 1'b1;
         end
         S_GAP: begin
            if (r_per_cnt != PER_W'(GAP_BITS - 1)) w_nxt_bit = 1'b1;
            else                                   w_from_gap = 1'b1;
         end
         default: ;
      endcase

      if (w_from_data) begin
         if (PARITY_MODE != PARITY_NONE) begin
            w_nxt_state = S_PARITY;
            w_nxt_bit   = r_par;
         end else begin
            w_from_par = 1'b1;
         end
      end
      if (w_from_par) begin
         if (STOP_BITS != 0) begin
            w_nxt_state = S_STOP;
            w_nxt_bit   = 1'b1;
         end else begin
            w_from_stop = 1'b1;
         end
      end
      if (w_from_stop) begin
         if (w_last) begin
            w_nxt_state = S_DONE;
            w_nxt_bit   = 1'b1;
         end else if (GAP_BITS != 0) begin
            w_nxt_state = S_GAP;
            w_nxt_bit   = 1'b1;
         end else begin
            w_from_gap = 1'b1;
         end
      end
      if (w_from_gap) begin
         w_load      = 1'b1;
         w_nxt_state = (START_EN != 0) ? S_START : S_DATA;
         w_nxt_bit   = (START_EN != 0) ? 1'b0 : r_frame[0];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= S_IDLE;
         r_out_bit  <= 1'b1;
         r_in_ready <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_data     <= '0;
         r_frame    <= '0;
         r_par      <= 1'b0;
         r_len      <= '0;
         r_byte_idx <= '0;
         r_bit_idx  <= '0;
         r_per_cnt  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               r_state <= S_IDLE;
               if (in_valid) begin
                  r_len      <= w_len_clamped;
                  r_byte_idx <= '0;
                  r_bit_idx  <= '0;
                  r_per_cnt  <= '0;
                  r_data     <= full_data[BYTE_SIZE-1:0];
                  r_frame    <= full_data >> BYTE_SIZE;
                  r_par      <= w_acc_par;
                  if (w_len_clamped == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= (START_EN != 0) ? S_START : S_DATA;
                     r_out_bit  <= (START_EN != 0) ? 1'b0 : full_data[0];
                     r_busy     <= 1'b1;
                     r_in_ready <= 1'b0;
                  end
               end
            end
            default: begin
               if (w_tick) begin
                  r_state   <= w_nxt_state;
                  r_out_bit <= w_nxt_bit;
                  if ((r_state == S_DATA) && (w_nxt_state == S_DATA)) begin
                     r_bit_idx <= r_bit_idx + BIT_W'(1);
                     r_data    <= r_data >> 1;
                  end
                  if (((r_state == S_STOP) || (r_state == S_GAP)) && (w_nxt_state == r_state))
                     r_per_cnt <= r_per_cnt + PER_W'(1);
                  else
                     r_per_cnt <= '0;
                  // Next byte load overrides the data shift when bytes are contiguous.
                  if (w_load) begin
                     r_data     <= r_frame[BYTE_SIZE-1:0];
                     r_frame    <= r_frame >> BYTE_SIZE;
                     r_par      <= w_ld_par;
                     r_byte_idx <= r_byte_idx + LEN_W'(1);
                     r_bit_idx  <= '0;
                  end
                  if (w_nxt_state == S_DONE) begin
                     r_done     <= 1'b1;
                     r_busy     <= 1'b0;
                     r_in_ready <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: three configurations, expected line
// levels per cycle queued at stimulus time and popped as the DUT drives them.
module tb_uart_frame_tx;

   logic        CLK = 1'b0;
   logic        RST;
   logic [39:0] full_data;
   logic [2:0]  len;
   logic [2:0]  in_valid;
   logic [2:0]  in_ready;
   logic [2:0]  out_bit;
   logic [2:0]  busy;
   logic [2:0]  done;

   int n_cmp = 0;
   int n_err = 0;
   bit exp_q[$];

   always #5 CLK = ~CLK;

   // 0: defaults; 1: even parity + 2 gap bits; 2: odd parity, 2 stop bits, 3 clks/bit
   uart_frame_tx u_dut0 (
      .CLK (CLK), .RST (RST), .full_data (full_data), .len (len), .in_valid (in_valid[0]),
      .in_ready (in_ready[0]), .out_bit (out_bit[0]), .busy (busy[0]), .done (done[0])
   );
   uart_frame_tx #(.PARITY_MODE (1), .GAP_BITS (2)) u_dut1 (
      .CLK (CLK), .RST (RST), .full_data (full_data), .len (len), .in_valid (in_valid[1]),
      .in_ready (in_ready[1]), .out_bit (out_bit[1]), .busy (busy[1]), .done (done[1])
   );
   uart_frame_tx #(.PARITY_MODE (2), .STOP_BITS (2), .CLKS_PER_BIT (3)) u_dut2 (
      .CLK (CLK), .RST (RST), .full_data (full_data), .len (len), .in_valid (in_valid[2]),
      .in_ready (in_ready[2]), .out_bit (out_bit[2]), .busy (busy[2]), .done (done[2])
   );

   function automatic int cfg_clk(input int d);  return (d == 2) ? 3 : 4; endfunction
   function automatic int cfg_par(input int d);  return d;                endfunction
   function automatic int cfg_stop(input int d); return (d == 2) ? 2 : 1; endfunction
   function automatic int cfg_gap(input int d);  return (d == 1) ? 2 : 0; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push_n(input bit v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v);
   endtask

   // Reference line waveform, one entry per clock cycle.
   task automatic build(input int d, input logic [39:0] data, input int l);
      int          c;
      int          lc;
      logic [7:0]  b;
      bit          p;
      c  = cfg_clk(d);
      lc = (l > 5) ? 5 : l;
      for (int k = 0; k < lc; k++) begin
         b = data[k*8 +: 8];
         p = ^b;
         if (cfg_par(d) == 2) p = ~p;
         push_n(1'b0, c);
         for (int i = 0; i < 8; i++) push_n(b[i], c);
         if (cfg_par(d) != 0) push_n(p, c);
         push_n(1'b1, c * cfg_stop(d));
         if (k < lc - 1) push_n(1'b1, c * cfg_gap(d));
      end
   endtask

   task automatic start(input int d, input logic [39:0] data, input int l, input string tag);
      full_data   = data;
      len         = 3'(l);
      in_valid[d] = 1'b1;
      @(posedge CLK); #1;
      in_valid[d] = 1'b0;
      chk({tag, ".busy_acc"},  32'(busy[d]),     32'((l != 0) ? 1 : 0));
      chk({tag, ".ready_acc"}, 32'(in_ready[d]), 32'((l == 0) ? 1 : 0));
      build(d, data, l);
   endtask

   // Pops one expected level per cycle, then checks the done cycle.
   task automatic check_stream(input int d, input bit disturb, input bit chain, input string tag);
      int n;
      bit e;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         chk({tag, ".bit"},    32'(out_bit[d]), 32'(e));
         chk({tag, ".nodone"}, 32'(done[d]),    32'd0);
         if (disturb && i == 8) begin
            in_valid[d] = 1'b1;
            full_data   = ~full_data;
            len         = 3'd5;
         end
         if (disturb && i == 16) in_valid[d] = 1'b0;
         if (chain && i == n - 1) in_valid[d] = 1'b1;
         @(posedge CLK); #1;
      end
      chk({tag, ".done"},       32'(done[d]),     32'd1);
      chk({tag, ".busy_end"},   32'(busy[d]),     32'd0);
      chk({tag, ".ready_end"},  32'(in_ready[d]), 32'd1);
      chk({tag, ".line_end"},   32'(out_bit[d]),  32'd1);
      @(posedge CLK); #1;
      if (chain) in_valid[d] = 1'b0;
      else       chk({tag, ".done_once"}, 32'(done[d]), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      RST       = 1'b1;
      in_valid  = 3'b111;
      full_data = 40'h00_03_aa_bb_47;
      len       = 3'd3;
      for (int c = 0; c < 5; c++) begin
         @(posedge CLK); #1;
         for (int d = 0; d < 3; d++) begin
            chk("rst.out_bit",  32'(out_bit[d]),  32'd1);
            chk("rst.in_ready", 32'(in_ready[d]), 32'd1);
            chk("rst.busy",     32'(busy[d]),     32'd0);
            chk("rst.done",     32'(done[d]),     32'd0);
         end
      end
      in_valid = 3'b000;
      RST      = 1'b0;
      @(posedge CLK); #1;
      for (int d = 0; d < 3; d++) chk("rst.nothing_accepted", 32'(busy[d]), 32'd0);

      // Basic 3-byte frame, 120 cycles, then len=0 and clamped len=7.
      start(0, 40'h00_03_aa_bb_47, 3, "basic");
      check_stream(0, 1'b0, 1'b0, "basic");
      start(0, 40'h12_34_56_78_9a, 0, "len0");
      chk("len0.line", 32'(out_bit[0]), 32'd1);
      check_stream(0, 1'b0, 1'b0, "len0");
      start(0, 40'h11_22_33_44_55, 7, "clamp");
      check_stream(0, 1'b0, 1'b0, "clamp");

      // Mid-frame input changes and in_valid must not disturb the frame.
      start(0, 40'h00_00_c3_5a_e1, 3, "ignore");
      check_stream(0, 1'b1, 1'b0, "ignore");

      // Reset in the middle of byte 0, then a clean frame.
      start(0, 40'h00_00_f0_0f_81, 3, "rstmid");
      for (int i = 0; i < 30; i++) begin
         chk("rstmid.bit", 32'(out_bit[0]), 32'(exp_q.pop_front()));
         @(posedge CLK); #1;
      end
      exp_q.delete();
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      chk("rstmid.line",  32'(out_bit[0]),  32'd1);
      chk("rstmid.busy",  32'(busy[0]),     32'd0);
      chk("rstmid.ready", 32'(in_ready[0]), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("rstmid.nodone", 32'(done[0]), 32'd0);
         @(posedge CLK); #1;
      end
      start(0, 40'h00_00_00_a5_3c, 2, "after_rst");
      check_stream(0, 1'b0, 1'b0, "after_rst");

      // Back-to-back: second request held through the done cycle.
      start(0, 40'h00_00_00_81_7e, 2, "b2b_a");
      full_data = 40'h00_00_00_00_d2;
      len       = 3'd1;
      check_stream(0, 1'b0, 1'b1, "b2b_a");
      chk("b2b_b.busy_acc", 32'(busy[0]), 32'd1);
      build(0, 40'h00_00_00_00_d2, 1);
      check_stream(0, 1'b0, 1'b0, "b2b_b");

      // Even parity with gap bits, including a back-to-back pair.
      start(1, 40'h00_00_00_00_47, 1, "even47");
      check_stream(1, 1'b0, 1'b0, "even47");
      start(1, 40'h00_00_00_00_bb, 1, "evenbb");
      check_stream(1, 1'b0, 1'b0, "evenbb");
      start(1, 40'h00_00_01_80_fe, 3, "gap");
      full_data = 40'h00_00_00_3c_c3;
      len       = 3'd2;
      check_stream(1, 1'b0, 1'b1, "gap");
      chk("gap2.busy_acc", 32'(busy[1]), 32'd1);
      build(1, 40'h00_00_00_3c_c3, 2);
      check_stream(1, 1'b0, 1'b0, "gap2");

      // Odd parity, two stop bits, 3 clocks per bit.
      start(2, 40'h00_00_00_00_47, 1, "odd47");
      check_stream(2, 1'b0, 1'b0, "odd47");
      start(2, 40'h00_00_00_00_bb, 1, "oddbb");
      check_stream(2, 1'b0, 1'b0, "oddbb");
      start(2, 40'h00_00_00_96_69, 2, "odd2");
      check_stream(2, 1'b1, 1'b0, "odd2");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_frame_tx.md
Name: uart_frame_tx

Overview:
Parametrised multi-byte UART transmitter, the successor to uart_tx. It accepts a packed frame of up to MAX_BYTES bytes with a runtime length. It serialises the frame byte 0 first. Each byte is sent as start bit, data bits LSB first, optional parity and 0–2 stop bits, at a programmable bit period. It sits between the command/response logic and the physical TX pin, and pairs with uart_rx configured with matching start/stop settings.

Parameters:
FULL_DATA_SIZE, 40, width of the full_data bus in bits; must be a multiple of BYTE_SIZE
BYTE_SIZE, 8, data bits per character (5..9)
CLKS_PER_BIT, 4, CLK cycles per serial bit (>=1)
START_EN, 1, 1 = emit start bit (0) before each byte; 0 = none
STOP_BITS, 1, number of stop bits (1) after each byte: 0, 1 or 2
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
GAP_BITS, 0, idle-high bit periods inserted between consecutive bytes, not after the last byte
MAX_BYTES (derived), FULL_DATA_SIZE/BYTE_SIZE
LEN_W (derived), $clog2(MAX_BYTES+1)

Ports:
CLK  input  1  clock
RST  input  1  synchronous, active-high reset
full_data  input  FULL_DATA_SIZE  frame; byte k = full_data[k*BYTE_SIZE +: BYTE_SIZE]
len  input  LEN_W  number of bytes to send; sampled on accept
in_valid  input  1  request to send
in_ready  output  1  block idle, can accept
out_bit  output  1  serial line, idle high
busy  output  1  frame in progress
done  output  1  one-cycle pulse at end of frame

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: out_bit=1, in_ready=1, busy=0, done=0. Internal counters are cleared and the FSM goes to IDLE.
- Reset mid-frame: the frame is aborted at the next CLK edge. out_bit=1 and no done pulse is produced.
- Accept: the frame is accepted when in_valid && in_ready at edge N. full_data and len are registered at that edge; later input changes have no effect.
- Accept timing: in_ready and busy change at the same edge N.
- Length clamp: len > MAX_BYTES is clamped to MAX_BYTES.
- Zero length: len=0 is accepted and emits no bits. done pulses in cycle N+1 and in_ready returns to 1 in cycle N+1.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> GAP -> (START of next byte | DONE) -> IDLE.
  - States disabled by parameter are skipped: START if START_EN=0, PARITY if PARITY_MODE=0, STOP if STOP_BITS=0, GAP if GAP_BITS=0.
  - Each bit state holds out_bit for exactly CLKS_PER_BIT cycles.
  - DATA counts BYTE_SIZE bits; STOP counts STOP_BITS periods; GAP counts GAP_BITS periods with out_bit=1.
- Latency: the first serial bit appears on out_bit from cycle N+1. out_bit is registered.
- Parity:
  - even: XOR of the data bits.
  - odd: inverted XOR of the data bits.
- Frame length: per-byte bits B = START_EN + BYTE_SIZE + (PARITY_MODE!=0) + STOP_BITS. A len=L frame occupies L*B*CLKS_PER_BIT + (L-1)*GAP_BITS*CLKS_PER_BIT cycles.
- End of frame: done=1 for the single cycle after the last bit period ends. In that same cycle busy=0, in_ready=1 and out_bit=1.
- Back-to-back: a new in_valid may be accepted in that done cycle. The next start bit then follows with no idle cycle beyond that one.
- Edge cases:
  - in_valid while busy is ignored; the request is not queued.
  - STOP_BITS=0 with GAP_BITS=0 gives byte-to-byte contiguity.
- Counters:
  - Baud counter width $clog2(CLKS_PER_BIT), wraps at CLKS_PER_BIT-1.
  - Byte index width LEN_W.
  - Bit index width $clog2(BYTE_SIZE).
  - No counter may overflow for any legal parameter set.

Decomposition:
- Package uart_pkg:
  - PARITY_NONE/EVEN/ODD constants.
  - FSM state encoding shared with a future uart_frame_rx.
  - Function uart_bits_per_char(START_EN, BYTE_SIZE, PARITY_MODE, STOP_BITS).
- Sub-module uart_baud_gen: CLKS_PER_BIT counter with sync clear.
  - Outputs a one-cycle bit_tick.
  - Reused by the RX side.

Test Plan:
1. Reset values: hold RST for 5 cycles with in_valid=1 -> out_bit=1, in_ready=1, busy=0, done=0 throughout; nothing is accepted.
2. Default parameters, basic frame: full_data=40'h00_03_aa_bb_47, len=3, one in_valid pulse.
   - out_bit carries 0x47, 0xbb, 0xaa in that order.
   - 0x47 bit sequence is 0,1,1,1,0,0,0,1,0,1 (start, LSB..MSB, stop), each bit held 4 cycles.
   - Frame lasts 120 cycles; done pulses once at N+121.
3. PARITY_MODE=1 / 2 with len=1, byte 0x47 (popcount 4):
   - even mode: parity bit = 0.
   - odd mode: parity bit = 1.
   - Repeat with 0xbb (popcount 6) to give the same results.
4. len=0 -> no line activity; done pulses at N+1.
   len=7 with MAX_BYTES=5 -> exactly 5 bytes are sent.
5. Reset mid-frame: RST=1 mid-byte during a len=3 frame -> out_bit=1 at the next edge and no done pulse; a new frame after reset transmits correctly.
6. Back-to-back and options: second in_valid held through the done cycle -> next start bit at done+1. With GAP_BITS=2, exactly 8 high cycles appear between the stop bit and the next start bit. Mid-frame in_valid and full_data changes have no effect.
